// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MIPS memory-access stage: control-field codes,
// load/store opcodes and the access FSM state type.
package mem_stage_pkg;

  localparam logic [2:0] JB_NONE = 3'b000;
  localparam logic [2:0] JB_BEQ  = 3'b001;
  localparam logic [2:0] JB_BNE  = 3'b010;
  localparam logic [2:0] JB_J    = 3'b011;
  localparam logic [2:0] JB_JR   = 3'b100;

  localparam logic [1:0] DTR_RES  = 2'b00;
  localparam logic [1:0] DTR_LOAD = 2'b01;
  localparam logic [1:0] DTR_PC4  = 2'b10;
  localparam logic [1:0] DTR_LUI  = 2'b11;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  // Anything that is not an explicit byte/halfword opcode is treated as a word access.
  function automatic logic is_word_op(input logic [5:0] op);
    return !(op inside {OP_LB, OP_LH, OP_LBU, OP_LHU, OP_SB, OP_SH});
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane steering for the memory stage: store replication, byte
// enables, and load extraction with sign/zero extension (little-endian lanes).
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  be_o,
  output logic [31:0] ld_data_o,
  output logic        word_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte   = ld_raw_i[8*addr_lo_i +: 8];
    ld_half   = ld_raw_i[16*addr_lo_i[1] +: 16];
    st_data_o = st_data_i;
    be_o      = 4'b1111;
    ld_data_o = ld_raw_i;
    word_o    = is_word_op(op_i);
    case (op_i)
      OP_SB: begin
        st_data_o = {4{st_data_i[7:0]}};
        be_o      = 4'b0001 << addr_lo_i;
      end
      OP_SH: begin
        st_data_o = {2{st_data_i[15:0]}};
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      OP_LB: begin
        ld_data_o = {{24{ld_byte[7]}}, ld_byte};
        be_o      = 4'b0001 << addr_lo_i;
      end
      OP_LBU: begin
        ld_data_o = {24'b0, ld_byte};
        be_o      = 4'b0001 << addr_lo_i;
      end
      OP_LH: begin
        ld_data_o = {{16{ld_half[15]}}, ld_half};
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      OP_LHU: begin
        ld_data_o = {16'b0, ld_half};
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: req/ack data-memory access with upstream stall, branch/jump
// redirect and the MEM/WB register. Define MEM_SUBWORD_EN for byte/halfword accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        MEM_JumpBranch,
  input  logic [1:0]        MEM_DatatoReg,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemWrite,
  input  logic [4:0]        MEM_Rdes,
  input  logic [31:0]       MEM_RDataA,
  input  logic [31:0]       MEM_RDataB,
  input  logic [31:0]       MEM_JumpPC,
  input  logic [31:0]       MEM_BranchPC,
  input  logic [31:0]       MEM_Res,
  input  logic [31:0]       MEM_LuiData,
  input  logic [31:0]       MEM_PCFour,
  input  logic [31:0]       MEM_Inst,
  input  logic              MEM_Zero,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              WB_RegWrite,
  output logic [4:0]        WB_Rdes,
  output logic [31:0]       WB_WData,
  output logic [31:0]       WB_Inst
);

  state_e      state_q;
  logic        mem_op;
  logic        word_acc;
  logic        taken;
  logic [31:0] target;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic [31:0] addr_full;
  logic [31:0] wb_wdata_d;

  logic        wb_regwrite_q;
  logic [4:0]  wb_rdes_q;
  logic [31:0] wb_wdata_q;
  logic [31:0] wb_inst_q;

  assign mem_op = (MEM_DatatoReg == DTR_LOAD) || MEM_MemWrite;

`ifdef MEM_SUBWORD_EN
  mem_lane_align u_lane (
    .op_i      (MEM_Inst[31:26]),
    .addr_lo_i (MEM_Res[1:0]),
    .st_data_i (MEM_RDataB),
    .ld_raw_i  (dmem_rdata),
    .st_data_o (st_data),
    .be_o      (be),
    .ld_data_o (ld_data),
    .word_o    (word_acc)
  );
`else
  assign st_data  = MEM_RDataB;
  assign be       = 4'b1111;
  assign ld_data  = dmem_rdata;
  assign word_acc = 1'b1;
`endif

  // Request is live in the first cycle an op is present; upstream holds it stable until ack.
  assign addr_full  = word_acc ? {MEM_Res[31:2], 2'b00} : MEM_Res;
  assign dmem_addr  = addr_full[ADDR_W-1:0];
  assign dmem_req   = !rst && ((state_q == ST_WAIT) || mem_op);
  assign dmem_we    = dmem_req && MEM_MemWrite;
  assign dmem_wdata = st_data;
  assign dmem_be    = be;
  assign mem_stall  = dmem_req && !dmem_ack;

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (MEM_JumpBranch)
      JB_BEQ: begin taken = MEM_Zero;  target = MEM_BranchPC; end
      JB_BNE: begin taken = !MEM_Zero; target = MEM_BranchPC; end
      JB_J:   begin taken = 1'b1;      target = MEM_JumpPC;   end
      JB_JR:  begin taken = 1'b1;      target = MEM_RDataA;   end
      default: ;
    endcase
  end

  // A redirect waits behind an outstanding access so a store always lands first.
  assign redirect_valid = !rst && !mem_stall && taken;
  assign redirect_pc    = redirect_valid ? target : '0;

  always_comb begin
    case (MEM_DatatoReg)
      DTR_RES:  wb_wdata_d = MEM_Res;
      DTR_LOAD: wb_wdata_d = ld_data;
      DTR_PC4:  wb_wdata_d = MEM_PCFour;
      default:  wb_wdata_d = MEM_LuiData;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (mem_op && !dmem_ack) state_q <= ST_WAIT;
        ST_WAIT: if (dmem_ack) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB boundary: a stalled cycle becomes a bubble, keeping the last write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_regwrite_q <= 1'b0;
      wb_rdes_q     <= '0;
      wb_wdata_q    <= '0;
      wb_inst_q     <= '0;
    end else if (mem_stall) begin
      wb_regwrite_q <= 1'b0;
      wb_rdes_q     <= '0;
      wb_inst_q     <= '0;
    end else begin
      wb_regwrite_q <= MEM_RegWrite;
      wb_rdes_q     <= MEM_Rdes;
      wb_wdata_q    <= wb_wdata_d;
      wb_inst_q     <= MEM_Inst;
    end
  end

  assign WB_RegWrite = wb_regwrite_q;
  assign WB_Rdes     = wb_rdes_q;
  assign WB_WData    = wb_wdata_q;
  assign WB_Inst     = wb_inst_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream checked against a behavioural model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  MEM_JumpBranch;
  logic [1:0]  MEM_DatatoReg;
  logic        MEM_RegWrite, MEM_MemWrite, MEM_Zero;
  logic [4:0]  MEM_Rdes;
  logic [31:0] MEM_RDataA, MEM_RDataB, MEM_JumpPC, MEM_BranchPC;
  logic [31:0] MEM_Res, MEM_LuiData, MEM_PCFour, MEM_Inst;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rdes;
  logic [31:0] WB_WData, WB_Inst;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .MEM_JumpBranch(MEM_JumpBranch), .MEM_DatatoReg(MEM_DatatoReg),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Rdes(MEM_Rdes), .MEM_RDataA(MEM_RDataA), .MEM_RDataB(MEM_RDataB),
    .MEM_JumpPC(MEM_JumpPC), .MEM_BranchPC(MEM_BranchPC), .MEM_Res(MEM_Res),
    .MEM_LuiData(MEM_LuiData), .MEM_PCFour(MEM_PCFour), .MEM_Inst(MEM_Inst),
    .MEM_Zero(MEM_Zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .WB_RegWrite(WB_RegWrite), .WB_Rdes(WB_Rdes), .WB_WData(WB_WData),
    .WB_Inst(WB_Inst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MEM_JumpBranch = 3'b000; MEM_DatatoReg = 2'b00;
    MEM_RegWrite = 1'b0; MEM_MemWrite = 1'b0; MEM_Zero = 1'b0;
    MEM_Rdes = 5'd0; MEM_RDataA = 0; MEM_RDataB = 0; MEM_JumpPC = 0;
    MEM_BranchPC = 0; MEM_Res = 0; MEM_LuiData = 0; MEM_PCFour = 0;
    MEM_Inst = 0; dmem_ack = 1'b0; dmem_rdata = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_subword(input logic [5:0] op);
`ifdef MEM_SUBWORD_EN
    return (op == 6'h20 || op == 6'h21 || op == 6'h24 || op == 6'h25 ||
            op == 6'h28 || op == 6'h29);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_addr(input logic [5:0] op, input logic [31:0] res);
    return m_subword(op) ? res : (res / 4) * 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] res);
    int a;
    a = res % 4;
    if (!m_subword(op)) return 4'hF;
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 4'(1 << a);
    return (a >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d);
    if (!m_subword(op)) return d;
    if (op == 6'h28) return (d % 256) * 32'h01010101;
    if (op == 6'h29) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] res,
                                         input logic [31:0] raw);
    logic [31:0] v;
    int a;
    a = res % 4;
    if (!m_subword(op)) return raw;
    if (op == 6'h20 || op == 6'h24) begin
      v = (raw >> (8 * a)) % 256;
      if (op == 6'h20 && v >= 128) v = v - 256;
    end else begin
      v = (raw >> (16 * (a / 2))) % 65536;
      if (op == 6'h21 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    MEM_DatatoReg = 2'b01; MEM_Res = 32'h100;
    #2;
    n_checks++;
    if ({dmem_req, mem_stall} !== 2'b00) $display("FAIL rst_hold_req got=%b exp=00", {dmem_req, mem_stall});
    else n_pass++;
    tick();
    n_checks++;
    if ({WB_RegWrite, WB_Rdes, WB_WData, WB_Inst} !== 70'd0)
      $display("FAIL rst_wb_init got=%h exp=0", {WB_RegWrite, WB_Rdes, WB_WData, WB_Inst});
    else n_pass++;
    rst = 1'b0;
    clear_inputs();
    MEM_Res = 32'h55; MEM_RegWrite = 1'b1; MEM_Rdes = 5'd7; MEM_Inst = 32'h1234;
    tick();
    MEM_DatatoReg = 2'b01; MEM_Res = 32'h100; MEM_Inst = 32'h8C050100;
    #1;
    n_checks++;
    if (dmem_req !== 1'b1) $display("FAIL rst_lw_req got=%b exp=1", dmem_req);
    else n_pass++;
    tick();
    n_checks++;
    if ({WB_RegWrite, WB_WData} !== {1'b0, 32'h55})
      $display("FAIL rst_bubble got=%h exp=%h", {WB_RegWrite, WB_WData}, {1'b0, 32'h55});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({dmem_req, mem_stall, WB_RegWrite, WB_Rdes, WB_WData, WB_Inst} !== 72'd0)
      $display("FAIL rst_mid_wait got=%h exp=0",
               {dmem_req, mem_stall, WB_RegWrite, WB_Rdes, WB_WData, WB_Inst});
    else n_pass++;
    rst = 1'b0;
    clear_inputs();
    #1;
    n_checks++;
    if (dmem_req !== 1'b0) $display("FAIL rst_fsm_idle got=%b exp=0", dmem_req);
    else n_pass++;
    tick();
  endtask

  task automatic test_lw_delayed();
    int stalls;
    stalls = 0;
    clear_inputs();
    MEM_DatatoReg = 2'b01; MEM_Res = 32'h100; MEM_RegWrite = 1'b1;
    MEM_Rdes = 5'd5; MEM_Inst = 32'h8C050100;
    for (int c = 0; c < 3; c++) begin
      dmem_rdata = $urandom();
      #1;
      if (mem_stall === 1'b1) stalls++;
      tick();
      n_checks++;
      if ({WB_RegWrite, WB_Rdes, WB_Inst} !== 38'd0)
        $display("FAIL lw_bubble got=%h exp=0", {WB_RegWrite, WB_Rdes, WB_Inst});
      else n_pass++;
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    if (mem_stall === 1'b1) stalls++;
    n_checks++;
    if (stalls !== 3) $display("FAIL lw_stall_cycles got=%0d exp=3", stalls);
    else n_pass++;
    tick();
    n_checks++;
    if ({WB_RegWrite, WB_Rdes, WB_WData} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL lw_wb got=%h exp=%h", {WB_RegWrite, WB_Rdes, WB_WData},
               {1'b1, 5'd5, 32'hDEADBEEF});
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_sw_same_cycle();
    clear_inputs();
    MEM_MemWrite = 1'b1; MEM_Res = 32'h204; MEM_RDataB = 32'h12345678;
    MEM_Inst = 32'hAC000204; dmem_ack = 1'b1;
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall} !==
        {1'b1, 1'b1, 32'h204, 4'hF, 32'h12345678, 1'b0})
      $display("FAIL sw_port got=%h exp=%h",
               {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall},
               {1'b1, 1'b1, 32'h204, 4'hF, 32'h12345678, 1'b0});
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    MEM_JumpBranch = 3'b001; MEM_Zero = 1'b1; MEM_BranchPC = 32'h40;
    #1;
    n_checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h40})
      $display("FAIL beq_taken got=%h exp=%h", {redirect_valid, redirect_pc}, {1'b1, 32'h40});
    else n_pass++;
    MEM_Zero = 1'b0;
    #1;
    n_checks++;
    if ({redirect_valid, redirect_pc} !== 33'd0)
      $display("FAIL beq_not_taken got=%h exp=0", {redirect_valid, redirect_pc});
    else n_pass++;
    tick();
  endtask

  task automatic test_jal();
    clear_inputs();
    MEM_JumpBranch = 3'b011; MEM_DatatoReg = 2'b10; MEM_PCFour = 32'h1C;
    MEM_JumpPC = 32'h80; MEM_RegWrite = 1'b1; MEM_Rdes = 5'd31;
    #1;
    n_checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h80})
      $display("FAIL jal_redirect got=%h exp=%h", {redirect_valid, redirect_pc}, {1'b1, 32'h80});
    else n_pass++;
    tick();
    n_checks++;
    if (WB_WData !== 32'h1C) $display("FAIL jal_link got=%h exp=%h", WB_WData, 32'h1C);
    else n_pass++;
    clear_inputs();
  endtask

`ifdef MEM_SUBWORD_EN
  task automatic test_subword_load();
    clear_inputs();
    MEM_DatatoReg = 2'b01; MEM_Res = 32'h103; MEM_RegWrite = 1'b1;
    MEM_Inst = 32'h80000103; dmem_ack = 1'b1; dmem_rdata = 32'h80FFFFFF;
    tick();
    n_checks++;
    if (WB_WData !== 32'hFFFFFF80) $display("FAIL lb_sext got=%h exp=%h", WB_WData, 32'hFFFFFF80);
    else n_pass++;
    MEM_Inst = 32'h90000103;
    tick();
    n_checks++;
    if (WB_WData !== 32'h00000080) $display("FAIL lbu_zext got=%h exp=%h", WB_WData, 32'h80);
    else n_pass++;
    clear_inputs();
  endtask
`endif

  // ---------------- randomized stream ----------------
  task automatic test_random();
    logic [5:0]  ld_ops [5] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    logic [5:0]  st_ops [3] = '{6'h28, 6'h29, 6'h2B};
    logic [31:0] r, last_wdata, exp_wb, tgt;
    logic [5:0]  op;
    bit          is_mem, is_ld, is_st, stall_now, tk;
    int          kind, delay;
    last_wdata = WB_WData;
    for (int n = 0; n < 300; n++) begin
      clear_inputs();
      kind = $urandom_range(0, 3);
      is_ld = (kind == 1);
      is_st = (kind == 2);
      is_mem = is_ld || is_st;
      MEM_DatatoReg = is_ld ? 2'b01 : (is_st ? 2'($urandom_range(0, 1) * 2) : 2'($urandom_range(0, 3)));
      if (!is_ld && MEM_DatatoReg == 2'b01) MEM_DatatoReg = 2'b11;
      MEM_MemWrite = is_st;
      op = is_ld ? ld_ops[$urandom_range(0, 4)] : (is_st ? st_ops[$urandom_range(0, 2)] : 6'h00);
      r = $urandom();
      MEM_Inst = {op, r[25:0]};
      MEM_JumpBranch = 3'($urandom_range(0, 7));
      MEM_RegWrite = 1'($urandom_range(0, 1));
      MEM_Rdes = 5'($urandom());
      MEM_Zero = 1'($urandom_range(0, 1));
      MEM_RDataA = $urandom(); MEM_RDataB = $urandom(); MEM_JumpPC = $urandom();
      MEM_BranchPC = $urandom(); MEM_Res = $urandom(); MEM_LuiData = $urandom();
      MEM_PCFour = $urandom();
      delay = is_mem ? $urandom_range(0, 3) : 0;
      case (MEM_JumpBranch)
        3'd1: begin tk = MEM_Zero;  tgt = MEM_BranchPC; end
        3'd2: begin tk = !MEM_Zero; tgt = MEM_BranchPC; end
        3'd3: begin tk = 1'b1;      tgt = MEM_JumpPC;   end
        3'd4: begin tk = 1'b1;      tgt = MEM_RDataA;   end
        default: begin tk = 1'b0;   tgt = 0;            end
      endcase
      for (int c = 0; c <= delay; c++) begin
        dmem_ack = is_mem && (c == delay);
        dmem_rdata = $urandom();
        stall_now = is_mem && (c != delay);
        #1;
        n_checks++;
        if ({dmem_req, mem_stall} !== {is_mem, stall_now})
          $display("FAIL rnd_req_stall n=%0d got=%b exp=%b", n, {dmem_req, mem_stall}, {is_mem, stall_now});
        else n_pass++;
        n_checks++;
        if ({redirect_valid, redirect_pc} !== {tk && !stall_now, (tk && !stall_now) ? tgt : 32'd0})
          $display("FAIL rnd_redirect n=%0d got=%h exp=%h", n, {redirect_valid, redirect_pc},
                   {tk && !stall_now, (tk && !stall_now) ? tgt : 32'd0});
        else n_pass++;
        if (is_mem) begin
          n_checks++;
          if ({dmem_we, dmem_addr, dmem_be} !== {is_st, m_addr(op, MEM_Res), m_be(op, MEM_Res)} ||
              (is_st && dmem_wdata !== m_wdata(op, MEM_RDataB)))
            $display("FAIL rnd_port n=%0d got=%h exp=%h", n, {dmem_we, dmem_addr, dmem_be, dmem_wdata},
                     {is_st, m_addr(op, MEM_Res), m_be(op, MEM_Res), m_wdata(op, MEM_RDataB)});
          else n_pass++;
        end
        case (MEM_DatatoReg)
          2'b00:   exp_wb = MEM_Res;
          2'b01:   exp_wb = m_load(op, MEM_Res, dmem_rdata);
          2'b10:   exp_wb = MEM_PCFour;
          default: exp_wb = MEM_LuiData;
        endcase
        tick();
        n_checks++;
        if (stall_now) begin
          if ({WB_RegWrite, WB_Rdes, WB_Inst, WB_WData} !== {38'd0, last_wdata})
            $display("FAIL rnd_bubble n=%0d got=%h exp=%h", n,
                     {WB_RegWrite, WB_Rdes, WB_Inst, WB_WData}, {38'd0, last_wdata});
          else n_pass++;
        end else begin
          if ({WB_RegWrite, WB_Rdes, WB_Inst, WB_WData} !== {MEM_RegWrite, MEM_Rdes, MEM_Inst, exp_wb})
            $display("FAIL rnd_wb n=%0d got=%h exp=%h", n, {WB_RegWrite, WB_Rdes, WB_Inst, WB_WData},
                     {MEM_RegWrite, MEM_Rdes, MEM_Inst, exp_wb});
          else n_pass++;
          last_wdata = exp_wb;
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_lw_delayed();
    test_sw_same_cycle();
    test_branch();
    test_jal();
`ifdef MEM_SUBWORD_EN
    test_subword_load();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
